// File: rtl/alu_pkg.sv
// Shared encodings for the ALU decoder and the iterative execution unit.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shift of a DW-bit value, left or right, logical or arithmetic.
module alu_shift_step #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] value,
  input  logic          right,
  input  logic          arith,
  output logic [DW-1:0] shifted
);

  // Arithmetic fill reuses the current MSB; since every step refills it with
  // itself, it always equals the original operand's sign bit.
  always_comb begin
    if (right) shifted = {arith & value[DW-1], value[DW-1:1]};
    else       shifted = {value[DW-2:0], 1'b0};
  end

endmodule

// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle logic/arith ops, bit-serial shifts, valid/ready.
module alu_iterative
  import alu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    alu_control,
  input  logic          func7_5,
  input  logic [DW-1:0] opr_a,
  input  logic [DW-1:0] opr_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] result
);

  localparam int SW = $clog2(DW);

  alu_state_e    state;
  alu_op_e       op;
  logic [SW-1:0] cnt, shamt;
  logic [DW-1:0] shreg, step, comb_res;
  logic          right, arith, is_shift;

  assign op       = alu_op_e'(alu_control);
  assign shamt    = opr_b[SW-1:0];
  assign is_shift = (op == ALU_SLL) || (op == ALU_SR);
  assign in_ready = (state == IDLE);

  always_comb begin
    comb_res = '0;
    case (op)
      ALU_ADD:  comb_res = func7_5 ? opr_a - opr_b : opr_a + opr_b;
      ALU_SLT:  comb_res = {{(DW-1){1'b0}}, $signed(opr_a) < $signed(opr_b)};
      ALU_SLTU: comb_res = {{(DW-1){1'b0}}, opr_a < opr_b};
      ALU_XOR:  comb_res = opr_a ^ opr_b;
      ALU_OR:   comb_res = opr_a | opr_b;
      ALU_AND:  comb_res = opr_a & opr_b;
      // Only reached with shamt == 0: the operand passes through unchanged.
      ALU_SLL, ALU_SR: comb_res = opr_a;
      default:  comb_res = '0;
    endcase
  end

  alu_shift_step #(.DW(DW)) u_step (
    .value   (shreg),
    .right   (right),
    .arith   (arith),
    .shifted (step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      right     <= 1'b0;
      arith     <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (is_shift && shamt != '0) begin
            shreg <= opr_a;
            cnt   <= shamt;
            right <= (op == ALU_SR);
            arith <= (op == ALU_SR) && func7_5;
            state <= SHIFT;
          end else begin
            result    <= comb_res;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        SHIFT: begin
          shreg <= step;
          cnt   <= cnt - SW'(1);
          if (cnt == SW'(1)) begin
            result    <= step;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// Directed scoreboard bench for alu_iterative: results, latency, stall, reset abort.
module tb_alu_iterative;
  import alu_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    alu_control = '0;
  logic          func7_5 = 1'b0;
  logic [DW-1:0] opr_a = '0;
  logic [DW-1:0] opr_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  alu_iterative #(.DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .func7_5     (func7_5),
    .opr_a       (opr_a),
    .opr_b       (opr_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one op, wait for its accept, then measure latency and score the result.
  task automatic run_op(input string tag, input logic [2:0] ctrl, input logic f7,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] exp_res, input int exp_lat, input bit early_rdy);
    int cyc;
    bit busy_ok;
    logic [DW-1:0] exp_q;
    sb.push_back(exp_res);
    @(negedge clk);
    in_valid = 1'b1; alu_control = ctrl; func7_5 = f7; opr_a = a; opr_b = b;
    cyc = 0;
    while (!in_ready && cyc < 100) begin @(negedge clk); cyc++; end
    check({tag, " accept"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Inputs must be ignored after the accept edge.
    in_valid = 1'b0; alu_control = 3'($urandom); func7_5 = 1'($urandom);
    opr_a = $urandom; opr_b = $urandom; out_ready = early_rdy;
    cyc = 1; busy_ok = 1'b1;
    while (!out_valid && cyc <= DW + 4) begin
      busy_ok &= !in_ready;
      @(negedge clk);
      cyc++;
    end
    exp_q = sb.pop_front();
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " result"}, result, exp_q);
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, " release"}, {30'd0, out_valid, in_ready}, 32'b01);
    out_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    bit stable;
    logic [DW-1:0] held, exp_q;

    #12;
    check("reset", {in_ready, out_valid, result[29:0]}, 32'h8000_0000);
    @(negedge clk); rst_n = 1'b1;

    run_op("sub",     ALU_ADD,  1'b1, 32'd5,          32'd7,          32'hFFFF_FFFE, 1, 1'b0);
    run_op("add",     ALU_ADD,  1'b0, 32'd5,          32'd7,          32'd12,        1, 1'b0);
    run_op("addwrap", ALU_ADD,  1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,         1, 1'b0);
    run_op("slt",     ALU_SLT,  1'b0, 32'hFFFF_FFFF,  32'd1,          32'd1,         1, 1'b0);
    run_op("sltu",    ALU_SLTU, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,         1, 1'b0);
    run_op("sltneg",  ALU_SLT,  1'b0, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd1,         1, 1'b0);
    run_op("xor",     ALU_XOR,  1'b1, 32'hF0F0_1234,  32'h0FF0_FF00,  32'hFF00_ED34, 1, 1'b0);
    run_op("or",      ALU_OR,   1'b0, 32'hF0F0_1234,  32'h0FF0_FF00,  32'hFFF0_FF34, 1, 1'b0);
    run_op("and",     ALU_AND,  1'b0, 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200, 1, 1'b0);
    run_op("sra31",   ALU_SR,   1'b1, 32'h8000_0000,  32'd31,         32'hFFFF_FFFF, 32, 1'b0);
    run_op("srl31",   ALU_SR,   1'b0, 32'h8000_0000,  32'd31,         32'h0000_0001, 32, 1'b0);
    run_op("sll5",    ALU_SLL,  1'b0, 32'd1,          32'h25,         32'h20,        6, 1'b0);
    run_op("sll0",    ALU_SLL,  1'b0, 32'h1234,       32'h20,         32'h1234,      1, 1'b0);
    run_op("srapos",  ALU_SR,   1'b1, 32'h7000_0000,  32'd4,          32'h0700_0000, 5, 1'b1);
    run_op("sraneg",  ALU_SR,   1'b1, 32'hF000_0000,  32'd4,          32'hFF00_0000, 5, 1'b0);
    run_op("sllf7",   ALU_SLL,  1'b1, 32'd3,          32'd2,          32'd12,        3, 1'b1);

    // Backpressure: hold the result, then release with the next request pending.
    sb.push_back(32'd123);
    @(negedge clk);
    in_valid = 1'b1; alu_control = ALU_ADD; func7_5 = 1'b0; opr_a = 32'd100; opr_b = 32'd23;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp valid", {31'd0, out_valid}, 32'd1);
    held = result; stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      stable &= out_valid && !in_ready && (result === held);
    end
    check("bp stable", {31'd0, stable}, 32'd1);
    exp_q = sb.pop_front();
    check("bp result", result, exp_q);
    sb.push_back(32'd7);
    in_valid = 1'b1; alu_control = ALU_ADD; func7_5 = 1'b1; opr_a = 32'd10; opr_b = 32'd3;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp idle", {30'd0, out_valid, in_ready}, 32'b01);
    @(negedge clk);
    in_valid = 1'b0;
    exp_q = sb.pop_front();
    check("bp next valid", {31'd0, out_valid}, 32'd1);
    check("bp next result", result, exp_q);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during the third step of a 20-step shift.
    @(negedge clk);
    in_valid = 1'b1; alu_control = ALU_SLL; func7_5 = 1'b0; opr_a = 32'd1; opr_b = 32'd20;
    cyc = 0;
    while (!in_ready && cyc < 100) begin @(negedge clk); cyc++; end
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst abort", {in_ready, out_valid, result[29:0]}, 32'h8000_0000);
    check("rst result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("post rst", ALU_SLL, 1'b0, 32'd1, 32'd3, 32'd8, 4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
